muldiv_ctrl: RTL and testbench

//  Execute-stage sequencer for the multi-cycle MULT/MULTU/DIV/DIVU ops decoded by aludec.

---
 rtl/muldiv_ctrl.sv | 135 +++++++++++++
 tb/tb_muldiv_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// Execute-stage sequencer for MULT/MULTU/DIV/DIVU: stalls the pipeline while the
// multiplier or the 32-step restoring divider runs, then issues one HI/LO write.
module muldiv_ctrl #(
  parameter int         MUL_CYCLES = 2,
  parameter logic [4:0] OP_MULT    = 5'b01000,
  parameter logic [4:0] OP_MULTU   = 5'b01001,
  parameter logic [4:0] OP_DIV     = 5'b01010,
  parameter logic [4:0] OP_DIVU    = 5'b01011
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [4:0]  op_i,
  input  logic [31:0] src_a_i,
  input  logic [31:0] src_b_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        busy_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        hilo_we_o,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  localparam logic [7:0] MUL_LAST = 8'(MUL_CYCLES - 1);
  localparam logic [7:0] DIV_LAST = 8'd31;

  state_t      state, state_next;
  logic [31:0] opa, opb, rem;
  logic [7:0]  cnt;
  logic        sgn, neg_q, neg_r;

  // Handshake: an op is accepted only in IDLE on valid_i & ~flush_i with a
  // muldiv code; stall_o holds upstream until the DONE cycle, where the op
  // retires together with the single-cycle hilo_we_o strobe.
  logic is_mul, is_div, is_signed, start;
  assign is_mul    = (op_i == OP_MULT) || (op_i == OP_MULTU);
  assign is_div    = (op_i == OP_DIV)  || (op_i == OP_DIVU);
  assign is_signed = (op_i == OP_MULT) || (op_i == OP_DIV);
  assign start     = valid_i && !flush_i && (is_mul || is_div);

  logic [31:0] a_abs, b_abs;
  assign a_abs = (is_signed && src_a_i[31]) ? (~src_a_i + 32'd1) : src_a_i;
  assign b_abs = (is_signed && src_b_i[31]) ? (~src_b_i + 32'd1) : src_b_i;

  // Both operands sign- or zero-extended to 66 bits; low 64 bits of the
  // product are exact for either signedness.
  logic [65:0] mul_a, mul_b, prod;
  assign mul_a = {{34{sgn & opa[31]}}, opa};
  assign mul_b = {{34{sgn & opb[31]}}, opb};
  assign prod  = mul_a * mul_b;

  // One restoring step: opa doubles as the dividend/quotient shift register.
  logic [32:0] rem_sh, diff;
  logic        take;
  logic [31:0] rem_nx, quo_nx;
  assign rem_sh = {rem, opa[31]};
  assign diff   = rem_sh - {1'b0, opb};
  assign take   = !diff[32];
  assign rem_nx = take ? diff[31:0] : rem_sh[31:0];
  assign quo_nx = {opa[30:0], take};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      opa   <= '0;
      opb   <= '0;
      rem   <= '0;
      cnt   <= '0;
      sgn   <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      hi_o  <= '0;
      lo_o  <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: if (start) begin
          cnt   <= '0;
          rem   <= '0;
          sgn   <= is_signed;
          neg_q <= is_div && is_signed && (src_a_i[31] ^ src_b_i[31]);
          neg_r <= is_div && is_signed && src_a_i[31];
          opa   <= is_div ? a_abs : src_a_i;
          opb   <= is_div ? b_abs : src_b_i;
          if (is_div && src_b_i == 32'd0) begin
            hi_o <= src_a_i;
            lo_o <= 32'hFFFF_FFFF;
          end
        end
        S_MUL: begin
          cnt <= cnt + 8'd1;
          if (!flush_i && cnt == MUL_LAST) begin
            hi_o <= prod[63:32];
            lo_o <= prod[31:0];
          end
        end
        S_DIV: begin
          cnt <= cnt + 8'd1;
          rem <= rem_nx;
          opa <= quo_nx;
          if (!flush_i && cnt == DIV_LAST) begin
            lo_o <= neg_q ? (~quo_nx + 32'd1) : quo_nx;
            hi_o <= neg_r ? (~rem_nx + 32'd1) : rem_nx;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start) begin
        if (is_mul)                  state_next = S_MUL;
        else if (src_b_i == 32'd0)   state_next = S_DONE;
        else                         state_next = S_DIV;
      end
      S_MUL:  if (cnt == MUL_LAST) state_next = S_DONE;
      S_DIV:  if (cnt == DIV_LAST) state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (flush_i) state_next = S_IDLE;
  end

  assign stall_o   = ((state == S_IDLE) && start) || (state == S_MUL) || (state == S_DIV);
  assign busy_o    = (state != S_IDLE);
  assign hilo_we_o = (state == S_DONE) && !flush_i;
  assign state_dbg = state;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: directed vector table, corner sequences (flush, reset,
// non-muldiv op) and random ops checked against an arithmetic reference model.
module tb_muldiv_ctrl;

  localparam int         MUL_CYCLES = 2;
  localparam logic [4:0] OP_MULT  = 5'b01000;
  localparam logic [4:0] OP_MULTU = 5'b01001;
  localparam logic [4:0] OP_DIV   = 5'b01010;
  localparam logic [4:0] OP_DIVU  = 5'b01011;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic [4:0]  op_i = '0;
  logic [31:0] src_a_i = '0, src_b_i = '0;
  logic        flush_i = 1'b0;
  logic        stall_o, busy_o, hilo_we_o;
  logic [31:0] hi_o, lo_o;
  logic [1:0]  state_dbg;

  int checks = 0;
  int failures = 0;

  muldiv_ctrl #(
    .MUL_CYCLES(MUL_CYCLES), .OP_MULT(OP_MULT), .OP_MULTU(OP_MULTU),
    .OP_DIV(OP_DIV), .OP_DIVU(OP_DIVU)
  ) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .op_i(op_i),
    .src_a_i(src_a_i), .src_b_i(src_b_i), .flush_i(flush_i),
    .stall_o(stall_o), .busy_o(busy_o), .hi_o(hi_o), .lo_o(lo_o),
    .hilo_we_o(hilo_we_o), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a, b, hi, lo;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic; SV division truncates toward
  // zero, so remainder sign follows the dividend as required.
  function automatic void model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo, output int lat);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == OP_MULT || op == OP_MULTU) begin
      if (op == OP_MULT) p = 64'(sa * sb);
      else               p = 64'(a) * 64'(b);
      hi = p[63:32]; lo = p[31:0]; lat = MUL_CYCLES + 1;
    end else if (b == 32'd0) begin
      hi = a; lo = 32'hFFFF_FFFF; lat = 1;
    end else begin
      if (op == OP_DIV) begin q = sa / sb; r = sa % sb; end
      else begin q = longint'(a / b); r = longint'(a % b); end
      hi = r[31:0]; lo = q[31:0]; lat = 33;
    end
  endfunction

  // Issues one op and follows it to its DONE cycle; if no_wait is set the
  // caller is already at a negedge where the op should be presented.
  task automatic run_op(input string name, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input int elat, input bit no_wait);
    int cyc;
    bit seen;
    bit stall_ok;
    if (!no_wait) @(negedge clk);
    valid_i = 1'b1; op_i = op; src_a_i = a; src_b_i = b;
    #1 chk({name, "_stall_t0"}, 64'(stall_o), 64'd1);
    @(posedge clk);
    #1;
    valid_i = 1'b0; op_i = 5'($urandom); src_a_i = $urandom; src_b_i = $urandom;
    cyc = 0; seen = 1'b0; stall_ok = 1'b1;
    while (cyc < 100 && !seen) begin
      @(negedge clk);
      cyc++;
      if (hilo_we_o) seen = 1'b1;
      else if (!stall_o) stall_ok = 1'b0;
    end
    chk({name, "_done_seen"}, 64'(seen), 64'd1);
    chk({name, "_stall_run"}, 64'(stall_ok), 64'd1);
    chk({name, "_latency"}, 64'(cyc), 64'(elat));
    chk({name, "_hilo"}, {hi_o, lo_o}, {ehi, elo});
    chk({name, "_stall_done"}, 64'(stall_o), 64'd0);
    @(negedge clk);
    chk({name, "_idle_after"}, {62'd0, busy_o, hilo_we_o}, 64'd0);
  endtask

  vec_t vecs[$];

  initial begin
    logic [31:0] ehi, elo;
    int          elat;

    vecs.push_back('{OP_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, MUL_CYCLES + 1});
    vecs.push_back('{OP_MULTU, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA, MUL_CYCLES + 1});
    vecs.push_back('{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33});
    vecs.push_back('{OP_DIVU,  32'h80000000, 32'h00000003, 32'h00000002, 32'h2AAAAAAA, 33});
    vecs.push_back('{OP_DIV,   32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1});
    vecs.push_back('{OP_DIVU,  32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1});
    vecs.push_back('{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33});
    vecs.push_back('{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33});
    vecs.push_back('{OP_DIV,   32'hFFFFFFF8, 32'h00000003, 32'hFFFFFFFE, 32'hFFFFFFFE, 33});
    vecs.push_back('{OP_DIVU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 33});
    vecs.push_back('{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MUL_CYCLES + 1});
    vecs.push_back('{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MUL_CYCLES + 1});

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {29'd0, stall_o, busy_o, hilo_we_o, hi_o}, 64'd0);
    chk("reset_lo", 64'(lo_o), 64'd0);
    rst = 1'b0;

    foreach (vecs[i]) run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                             vecs[i].hi, vecs[i].lo, vecs[i].lat, 1'b0);

    // Non-muldiv op is ignored
    @(negedge clk);
    valid_i = 1'b1; op_i = 5'b00000; src_a_i = 32'd9; src_b_i = 32'd3;
    #1 chk("nonmuldiv_stall", 64'(stall_o), 64'd0);
    @(negedge clk);
    valid_i = 1'b0;
    chk("nonmuldiv_busy", {62'd0, busy_o, hilo_we_o}, 64'd0);

    // Start together with flush: flush wins
    valid_i = 1'b1; op_i = OP_MULT; src_a_i = 32'd4; src_b_i = 32'd5; flush_i = 1'b1;
    #1 chk("flush_start_stall", 64'(stall_o), 64'd0);
    @(negedge clk);
    valid_i = 1'b0; flush_i = 1'b0;
    chk("flush_start_busy", {62'd0, busy_o, hilo_we_o}, 64'd0);

    // DIV cancelled by flush at T0+10, then MULT at T0+11
    begin
      bit no_we = 1'b1;
      valid_i = 1'b1; op_i = OP_DIV; src_a_i = 32'd100; src_b_i = 32'd7;
      @(posedge clk);
      #1 valid_i = 1'b0;
      for (int c = 1; c <= 10; c++) begin
        @(negedge clk);
        if (hilo_we_o) no_we = 1'b0;
        if (c == 10) flush_i = 1'b1;
      end
      #1 if (hilo_we_o) no_we = 1'b0;
      @(negedge clk);
      flush_i = 1'b0;
      chk("flush_div_no_we", 64'(no_we), 64'd1);
      chk("flush_div_idle", {62'd0, busy_o, hilo_we_o}, 64'd0);
      run_op("post_flush_mult", OP_MULT, 32'hFFFFFFFE, 32'h00000003,
             32'hFFFFFFFF, 32'hFFFFFFFA, MUL_CYCLES + 1, 1'b1);
    end

    // Reset in the middle of a divide
    @(negedge clk);
    valid_i = 1'b1; op_i = OP_DIVU; src_a_i = 32'd1000; src_b_i = 32'd3;
    @(posedge clk);
    #1 valid_i = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midop_reset_ctrl", {61'd0, stall_o, busy_o, hilo_we_o}, 64'd0);
    chk("midop_reset_hilo", {hi_o, lo_o}, 64'd0);
    rst = 1'b0;

    // Random ops against the model
    for (int n = 0; n < 40; n++) begin
      logic [4:0]  rop;
      logic [31:0] ra, rb;
      case ($urandom_range(0, 3))
        0: rop = OP_MULT;
        1: rop = OP_MULTU;
        2: rop = OP_DIV;
        default: rop = OP_DIVU;
      endcase
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 :
           ($urandom_range(0, 1) ? 32'($urandom) : 32'($urandom_range(1, 300)));
      if ($urandom_range(0, 1)) ra = 32'($signed(ra) >>> $urandom_range(0, 31));
      model(rop, ra, rb, ehi, elo, elat);
      run_op($sformatf("rnd%0d", n), rop, ra, rb, ehi, elo, elat, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
